ysyx_23060236_mdu: RTL and testbench
====================================

YSYX_23060236_MDU -- requirements
Module: ysyx_23060236_mdu

Interface
REQ-001 SHALL have parameter DIV_MIN_LAT, default 34, meaning the minimum number of DWAIT cycles before div_outvalid is trusted.
REQ-002 SHALL have port clock  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  in  1  upstream request valid.
REQ-005 SHALL have port in_ready  out  1  high only in IDLE.
REQ-006 SHALL have port op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports src1, src2  in  32  operands rs1, rs2.
REQ-008 SHALL have port out_valid  out  1  result valid.
REQ-009 SHALL have port out_ready  in  1  downstream accepts the result.
REQ-010 SHALL have port out_data  out  32  result.
REQ-011 SHALL have port div_valid  out  1  divider launch request.
REQ-012 SHALL have port div_ready  in  1  divider idle.
REQ-013 SHALL have ports div_sign  out  1, div1  out  32, div2  out  32  divider signedness and operands.
REQ-014 SHALL have ports div_res  in  32, div_rem  in  32, div_outvalid  in  1  divider results.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, MFIX, DLAUNCH, DWAIT, DONE.
REQ-016 SHALL latch op, src1 and src2 on accept (in_valid & in_ready).
REQ-017 SHALL NOT let in_valid affect state outside IDLE.
REQ-018 SHALL route an accepted op[2]=0 from IDLE to MUL.
REQ-019 SHALL route DIV/DIVU/REM/REMU with src2==0 from IDLE directly to DONE, without asserting div_valid; quotient 0xFFFFFFFF, remainder src1.
REQ-020 SHALL route signed DIV/REM with src1==0x80000000 and src2==0xFFFFFFFF from IDLE directly to DONE; quotient 0x80000000, remainder 0.
REQ-021 SHALL route every other divide from IDLE to DLAUNCH.
REQ-022 SHALL compute multiplies as unsigned 32x32 shift-add over operand magnitudes.
REQ-023 Multiply signedness: src1 signed for MUL/MULH/MULHSU; src2 signed for MUL/MULH only.
REQ-024 SHALL process one multiplier bit per cycle in MUL, for exactly 32 cycles (6-bit counter), then go to MFIX.
REQ-025 MFIX SHALL negate the 64-bit product when the operand signs differ, then go to DONE.
REQ-026 SHALL output product[31:0] for MUL and product[63:32] for the other multiplies.
REQ-027 In DLAUNCH, SHALL hold div_valid=1, div_sign=~op[0], div1=src1, div2=src2.
REQ-028 SHALL leave DLAUNCH for DWAIT on the first cycle div_valid & div_ready, and clear the DWAIT counter at that point.
REQ-029 SHALL keep div_valid=0 in every state other than DLAUNCH.
REQ-030 In DWAIT, SHALL capture div_res (op[1]=0) or div_rem (op[1]=1) on the first cycle div_outvalid=1 with counter>=DIV_MIN_LAT, then go to DONE.
REQ-031 SHALL NOT treat a div_outvalid that is already high on entry to DWAIT as completion.
REQ-032 SHALL hold out_valid=1 in DONE, with out_data stable until the out_valid & out_ready handshake, then return to IDLE.
REQ-033 SHALL hold out_data at 0 when not in DONE.
REQ-034 Latency from accept edge to out_valid: multiply 34 cycles; special-case divide 1 cycle; normal divide DLAUNCH wait + DIV_MIN_LAT + 1 cycles minimum.
REQ-035 SHALL accept a new request only on the cycle after the DONE handshake (IDLE again); no back-to-back accept in the same cycle.

Reset
REQ-036 On reset, SHALL go to IDLE and clear the counters.
REQ-037 On reset, SHALL drive out_valid=0, out_data=0, div_valid=0, in_ready=1 on the following cycle.
REQ-038 Reset mid-MUL or mid-DWAIT SHALL discard the operation; no out_valid for it.
REQ-039 A divider result arriving after reset SHALL be ignored.

Verification
REQ-040 MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB after 34 cycles; MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-041 DIV 0xFFFFFFF9 / 2 with a stub divider -> div_sign=1, div1=0xFFFFFFF9, div2=2; out 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-042 DIVU 5 / 0 -> out 0xFFFFFFFF one cycle after accept, div_valid never high; REMU 5 / 0 -> 5.
REQ-043 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; div_valid never high.
REQ-044 out_ready=0 for 10 cycles in DONE -> out_valid and out_data held, in_ready=0; stub div_outvalid stuck high from the prior op -> no early completion.
REQ-045 Reset asserted at MUL cycle 10 -> next cycle in_ready=1, out_valid=0; a new MULHU 0xFFFFFFFF x 0xFFFFFFFF then completes normally with 0xFFFFFFFE.

Source files
------------

// File: rtl/ysyx_23060236_mdu_if.sv
// rtl/ysyx_23060236_mdu_if.sv - request/response and divider handshake bundle for the MDU
interface ysyx_23060236_mdu_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        div_valid;
  logic        div_ready;
  logic        div_sign;
  logic [31:0] div1;
  logic [31:0] div2;
  logic [31:0] div_res;
  logic [31:0] div_rem;
  logic        div_outvalid;

  // MDU side
  modport slave (
    input  in_valid, op, src1, src2, out_ready, div_ready, div_res, div_rem, div_outvalid,
    output in_ready, out_valid, out_data, div_valid, div_sign, div1, div2
  );

  // pipeline / divider side
  modport master (
    output in_valid, op, src1, src2, out_ready, div_ready, div_res, div_rem, div_outvalid,
    input  in_ready, out_valid, out_data, div_valid, div_sign, div1, div2
  );
endinterface

// File: rtl/ysyx_23060236_mdu.sv
// rtl/ysyx_23060236_mdu.sv - RV32M unit: serial shift-add multiplier and external divider sequencer
module ysyx_23060236_mdu #(
  parameter int DIV_MIN_LAT = 34
) (
  input logic                clock,
  input logic                reset,
  ysyx_23060236_mdu_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MUL     = 3'd1;
  localparam logic [2:0] S_MFIX    = 3'd2;
  localparam logic [2:0] S_DLAUNCH = 3'd3;
  localparam logic [2:0] S_DWAIT   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // DWAIT counter saturates at DIV_MIN_LAT, so it only needs to hold that value
  localparam int             DCW  = $clog2(DIV_MIN_LAT + 2);
  localparam logic [DCW-1:0] DMIN = DCW'(DIV_MIN_LAT);

  logic [2:0]     state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [31:0]    src1_q, src1_d;
  logic [31:0]    src2_q, src2_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [63:0]    prod_q, prod_d;
  logic [31:0]    res_q, res_d;

  logic        s1_neg, s2_neg, in_s2_neg;
  logic [31:0] mag1, in_mag2;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;
  logic        div_zero, div_ovf;

  // operand signs/magnitudes: src1 signed unless MULHU, src2 signed only for MUL/MULH
  always_comb begin
    s1_neg    = (op_q[1:0] != 2'b11) & src1_q[31];
    s2_neg    = ~op_q[1] & src2_q[31];
    mag1      = s1_neg ? -src1_q : src1_q;
    in_s2_neg = ~bus.op[1] & bus.src2[31];
    in_mag2   = in_s2_neg ? -bus.src2 : bus.src2;
    mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mag1} : 33'd0);
    prod_fix  = (s1_neg ^ s2_neg) ? -prod_q : prod_q;
    div_zero  = (bus.src2 == 32'd0);
    div_ovf   = ~bus.op[0] & (bus.src1 == 32'h8000_0000) & (bus.src2 == 32'hFFFF_FFFF);
  end

  // next-state and datapath: the low half of prod holds the shrinking multiplier,
  // the high half accumulates, one multiplier bit retired per MUL cycle
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    prod_d  = prod_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d   = bus.op;
          src1_d = bus.src1;
          src2_d = bus.src2;
          cnt_d  = 6'd0;
          dcnt_d = '0;
          if (!bus.op[2]) begin
            prod_d  = {32'd0, in_mag2};
            state_d = S_MUL;
          end else if (div_zero) begin
            res_d   = bus.op[1] ? bus.src1 : 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else if (div_ovf) begin
            res_d   = bus.op[1] ? 32'd0 : 32'h8000_0000;
            state_d = S_DONE;
          end else begin
            state_d = S_DLAUNCH;
          end
        end
      end
      S_MUL: begin
        prod_d = {mul_sum, prod_q[31:1]};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = S_MFIX;
      end
      S_MFIX: begin
        res_d   = (op_q == 3'b000) ? prod_fix[31:0] : prod_fix[63:32];
        state_d = S_DONE;
      end
      S_DLAUNCH: begin
        if (bus.div_ready) begin
          dcnt_d  = '0;
          state_d = S_DWAIT;
        end
      end
      S_DWAIT: begin
        // the minimum-latency gate keeps a stale div_outvalid from completing early
        if (dcnt_q != DMIN) dcnt_d = dcnt_q + 1'b1;
        if (bus.div_outvalid && (dcnt_q == DMIN)) begin
          res_d   = op_q[1] ? bus.div_rem : bus.div_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      src1_q  <= 32'd0;
      src2_q  <= 32'd0;
      cnt_q   <= 6'd0;
      dcnt_q  <= '0;
      prod_q  <= 64'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = (state_q == S_DONE) ? res_q : 32'd0;
  assign bus.div_valid = (state_q == S_DLAUNCH);
  assign bus.div_sign  = ~op_q[0];
  assign bus.div1      = src1_q;
  assign bus.div2      = src2_q;

endmodule

// File: tb/tb_ysyx_23060236_mdu.sv
// tb/tb_ysyx_23060236_mdu.sv - randomized self-checking bench for the MDU with a stub divider
module tb_ysyx_23060236_mdu;
  localparam int DML = 34;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ysyx_23060236_mdu_if bus();
  ysyx_23060236_mdu #(.DIV_MIN_LAT(DML)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // stub divider: random latency, result stays valid until the next launch
  // (or across it when stuck_mode is set, modelling a stale completion flag)
  logic        stub_ready = 1'b1;
  logic        stub_ov    = 1'b0;
  logic [31:0] stub_res   = 32'd0;
  logic [31:0] stub_rem   = 32'd0;
  logic [63:0] stub_pend  = 64'd0;
  int          stub_left  = 0;
  int          stub_min_lat = 1;
  int          stub_max_lat = 60;
  bit          stuck_mode = 1'b0;
  int          launches = 0;
  int          dv_cycles = 0;
  logic        last_sign = 1'b0;
  logic [31:0] last_d1 = 32'd0;
  logic [31:0] last_d2 = 32'd0;

  assign bus.div_ready    = stub_ready;
  assign bus.div_outvalid = stub_ov;
  assign bus.div_res      = stub_res;
  assign bus.div_rem      = stub_rem;

  function automatic logic [63:0] stub_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    logic [31:0] q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'd0};
    if (sgn) begin ia = a; ib = b; q = ia / ib; r = ia % ib; end
    else begin q = a / b; r = a % b; end
    return {q, r};
  endfunction

  always @(posedge clock) begin
    if (bus.div_valid) dv_cycles <= dv_cycles + 1;
    if (bus.div_valid && stub_ready) begin
      launches   <= launches + 1;
      last_sign  <= bus.div_sign;
      last_d1    <= bus.div1;
      last_d2    <= bus.div2;
      stub_pend  <= stub_div(bus.div_sign, bus.div1, bus.div2);
      stub_left  <= $urandom_range(stub_max_lat, stub_min_lat);
      stub_ready <= 1'b0;
      if (!stuck_mode) stub_ov <= 1'b0;
    end else if (!stub_ready) begin
      if (stub_left <= 1) begin
        stub_res   <= stub_pend[63:32];
        stub_rem   <= stub_pend[31:0];
        stub_ov    <= 1'b1;
        stub_ready <= 1'b1;
      end else begin
        stub_left <= stub_left - 1;
      end
    end
  end

  // reference model straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = $signed(a); sb = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    ia = a; ib = b;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // drive one request, wait (bounded) for out_valid; leaves the DUT in DONE
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!bus.in_ready && guard < 200) begin @(negedge clock); guard++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, guard);
    end
    bus.in_valid = 1'b1; bus.op = o; bus.src1 = a; bus.src2 = b;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom); bus.src1 = $urandom; bus.src2 = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 300) begin @(negedge clock); lat++; end
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout: op=%0d out_valid=0 after %0d cycles, required 1", o, lat);
    end
    res = bus.out_data;
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_data} !== {2'b10, 32'd0}) begin
      errors++;
      $display("FAIL post_handshake: in_ready=%0b out_valid=%0b out_data=%h, required 1 0 00000000",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h, required 0", bus.out_data); end
    checks++;
    if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL reset_div_valid: got %b, required 0", bus.div_valid); end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat, l0;
    for (int i = 0; i < 4; i++) begin
      l0 = launches;
      run_op(ops[i], as[i], bs[i], res, lat);
      checks++;
      if (res !== exp[i]) begin errors++; $display("FAIL mul_vec%0d: got %h, required %h", i, res, exp[i]); end
      checks++;
      if (lat != 34) begin errors++; $display("FAIL mul_lat%0d: got %0d, required 34", i, lat); end
      checks++;
      if (launches != l0) begin errors++; $display("FAIL mul_launch%0d: got %0d launches, required 0", i, launches - l0); end
      finish_op();
    end
  endtask

  task automatic test_div_stub();
    logic [31:0] res;
    int lat;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, res, lat);
    checks++;
    if ({last_sign, last_d1, last_d2} !== {1'b1, 32'hFFFF_FFF9, 32'd2}) begin
      errors++;
      $display("FAIL div_operands: got sign=%b d1=%h d2=%h, required 1 fffffff9 00000002", last_sign, last_d1, last_d2);
    end
    checks++;
    if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_result: got %h, required fffffffd", res); end
    checks++;
    if (lat < DML + 2) begin errors++; $display("FAIL div_lat: got %0d, required >= %0d", lat, DML + 2); end
    finish_op();
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_result: got %h, required ffffffff", res); end
    finish_op();
  endtask

  task automatic test_div_special();
    logic [2:0]  ops [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    int lat, d0;
    for (int i = 0; i < 4; i++) begin
      d0 = dv_cycles;
      run_op(ops[i], as[i], bs[i], res, lat);
      checks++;
      if (res !== exp[i]) begin errors++; $display("FAIL special%0d_result: got %h, required %h", i, res, exp[i]); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL special%0d_lat: got %0d, required 1", i, lat); end
      checks++;
      if (dv_cycles != d0) begin errors++; $display("FAIL special%0d_div_valid: high %0d cycles, required 0", i, dv_cycles - d0); end
      finish_op();
    end
  endtask

  task automatic test_hold();
    logic [31:0] res, a, b, exp;
    int lat, bad;
    stuck_mode = 1'b1; stub_min_lat = 1; stub_max_lat = 30;
    a = $urandom; b = $urandom_range(1, 1000);
    exp = model(3'd5, a, b);
    run_op(3'd5, a, b, res, lat);
    checks++;
    if (res !== exp) begin errors++; $display("FAIL stuck_result: got %h, required %h", res, exp); end
    checks++;
    if (lat < DML + 2) begin errors++; $display("FAIL stuck_early: latency %0d, required >= %0d", lat, DML + 2); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.op = 3'($urandom); bus.src1 = $urandom; bus.src2 = $urandom;
      @(negedge clock);
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.in_ready !== 1'b0) bad++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_done: %0d cycles lost out_valid/out_data or raised in_ready, required 0", bad); end
    finish_op();
    stuck_mode = 1'b0; stub_max_lat = 60;
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] res;
    int lat, seen;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.op = 3'd3; bus.src1 = 32'h1234_5678; bus.src2 = 32'h9ABC_DEF0;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL mul_reset_state: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    repeat (40) begin @(negedge clock); if (bus.out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mul_reset_discard: out_valid high %0d cycles, required 0", seen); end
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFE || lat != 34) begin
      errors++; $display("FAIL mul_after_reset: got %h lat %0d, required fffffffe lat 34", res, lat);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_div();
    int seen;
    stub_min_lat = 20; stub_max_lat = 30; stuck_mode = 1'b0;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.op = 3'd4; bus.src1 = 32'd1000; bus.src2 = 32'd7;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (60) begin if (bus.out_valid || !bus.in_ready) seen++; @(negedge clock); end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL div_reset_discard: %0d cycles not idle, required 0", seen); end
    stub_min_lat = 1; stub_max_lat = 60;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, res, exp;
    int lat, l0, exp_l;
    bit normal_div;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom); a = pick(); b = pick();
      stuck_mode = 1'($urandom);
      stub_max_lat = stuck_mode ? 30 : 60;
      exp = model(o, a, b);
      normal_div = o[2] && (b != 0) && !(!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      exp_l = normal_div ? 1 : 0;
      l0 = launches;
      run_op(o, a, b, res, lat);
      checks++;
      if (res !== exp) begin errors++; $display("FAIL rand%0d_result: op=%0d a=%h b=%h got %h, required %h", i, o, a, b, res, exp); end
      checks++;
      if ((!o[2] && lat != 34) || (normal_div && lat < DML + 2) || (o[2] && !normal_div && lat != 1)) begin
        errors++; $display("FAIL rand%0d_lat: op=%0d b=%h got %0d cycles", i, o, b, lat);
      end
      checks++;
      if (launches - l0 != exp_l) begin errors++; $display("FAIL rand%0d_launch: got %0d, required %0d", i, launches - l0, exp_l); end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      finish_op();
    end
    stuck_mode = 1'b0; stub_max_lat = 60;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.src1 = 32'd0; bus.src2 = 32'd0; bus.out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div_stub();
    test_div_special();
    test_hold();
    test_reset_mid_mul();
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
